mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Sequences and shares the single pipelined main-memory port between the I-cache fill path (read-only block fills) and the D-cache path (block fills plus single-word write-through stores).
- Sits between the two cache fill FSMs and the main memory.
- Issues one word address per cycle during a block fill and tags returned words with their cache word address.
- Enforces I-first priority with a one-transaction anti-starvation guarantee for D.

Parameters:
- WORDS, 8, 16-bit words per cache block; block is 2*WORDS bytes; power of two.
- CNT_W, 3, log2(WORDS); width of the issue and return counters.

Ports:
- clk, input, 1, clock.
- rst, input, 1, synchronous active-high reset.
- i_req, input, 1, I-side block-fill request; held until i_done.
- i_addr, input, 16, I-side miss byte address.
- i_grant, output, 1, I transaction in progress.
- i_fill_valid, output, 1, i_fill_data is valid this cycle.
- i_fill_addr, output, 16, byte address of the returned word.
- i_fill_data, output, 16, returned word.
- i_done, output, 1, one-cycle I completion pulse.
- d_req, input, 1, D-side request; held until d_done.
- d_we, input, 1, D request type: 1 = single-word store, 0 = block fill.
- d_addr, input, 16, D-side byte address.
- d_wdata, input, 16, store data.
- d_grant, output, 1, D transaction in progress.
- d_fill_valid, output, 1, d_fill_data is valid this cycle.
- d_fill_addr, output, 16, byte address of the returned word.
- d_fill_data, output, 16, returned word.
- d_done, output, 1, one-cycle D completion pulse.
- mem_en, output, 1, memory enable.
- mem_wr, output, 1, memory write.
- mem_addr, output, 16, memory byte address.
- mem_wdata, output, 16, memory write data.
- mem_rdata, input, 16, memory read data.
- mem_valid, input, 1, memory read data valid.

Behaviour:
- Reset and idle values: every output is 0 after reset and in IDLE.
- States: IDLE, I_FILL, D_FILL, D_WRITE, DONE.
- Latched on grant: request address, d_wdata, owner, and last_owner.
- Block base address is {addr[15:log2(2*WORDS)], zeros}.
- IDLE arbitration (registered; the grant appears the cycle after the request is sampled):
  - Only i_req -> I_FILL.
  - Only d_req -> D_FILL if d_we=0, else D_WRITE.
  - Both requests -> I, unless last_owner==I, in which case D.
  - last_owner resets to D.
- I_FILL / D_FILL:
  - Owner grant=1 for the whole state.
  - Issue phase: while issue_cnt < WORDS, mem_en=1, mem_wr=0, mem_addr = base + 2*issue_cnt; issue_cnt increments by 1 per cycle, so there are exactly WORDS consecutive issue cycles.
  - Every mem_valid cycle in a fill state:
    - owner fill_valid=1, combinational, same cycle;
    - fill_data = mem_rdata;
    - fill_addr = base + 2*ret_cnt;
    - ret_cnt increments.
  - Returns may overlap the issue phase.
  - After the WORDS-th return -> DONE.
- D_WRITE:
  - One cycle: d_grant=1, mem_en=1, mem_wr=1, mem_addr = latched d_addr with bit 0 cleared, mem_wdata = latched data.
  - Next state DONE.
- DONE:
  - One cycle; owner done=1; grants 0; next state IDLE.
  - The mandatory IDLE cycle lets the requester drop req.
  - The next grant is no earlier than 2 cycles after done.
- Requests:
  - Deassertion of req mid-transaction is ignored; the transaction completes.
  - Address and data changes after grant are ignored.
- Stray returns: mem_valid in IDLE, D_WRITE or DONE is ignored, with no fill_valid.
- Counters: wrap modulo WORDS; they are cleared on entry to any fill state.
- Addressing: fill_addr and mem_addr never leave the block (no carry into tag bits).
- Non-owner outputs: the non-owner side's fill_valid, grant and done are always 0.
- Reset mid-transaction: state returns to IDLE and all outputs go to 0 the next cycle; in-flight memory returns after reset are ignored.

Test Plan:
- Single I miss: i_req=1, i_addr=0x1236 at cycle T; memory model latency 4.
  - i_grant from T+1; mem_addr 0x1230,0x1232,...,0x123E on T+1..T+8.
  - i_fill_valid T+5..T+12 with i_fill_addr 0x1230..0x123E.
  - i_done at T+13 only; IDLE at T+14.
- D store: d_req=1, d_we=1, d_addr=0x4003, d_wdata=0xBEEF.
  - Exactly one mem_en & mem_wr cycle with mem_addr=0x4002, mem_wdata=0xBEEF.
  - d_done the following cycle; no d_fill_valid.
- Simultaneous misses after reset: i_req and d_req both held.
  - I fill is served first.
  - The D fill is granted 2 cycles after i_done.
  - i_grant and d_grant are never both 1.
- Anti-starvation: i_req held continuously, d_req held.
  - Grants alternate I, D, I, D.
  - D never waits more than one I transaction.
- Reset mid-fill: assert rst at the 3rd issue cycle of a D fill.
  - Next cycle all outputs are 0.
  - Remaining mem_valid pulses from the model produce no d_fill_valid.
  - A fresh i_req then completes normally with 8 returns.
- Req drop: d_req deasserted 2 cycles into a D fill with d_addr=0xFFF8.
  - All 8 words still return, at 0xFFF0..0xFFFE, with no wrap past 0xFFFE.
  - d_done pulses once.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the I-cache fill path, the D-cache path and the main-memory port
//   of the memory port arbiter.
//   slave  : arbiter view. Takes requests and memory returns; drives grants,
//            fill returns, done pulses and memory commands.
//   master : environment view (the two cache FSMs plus the memory).
interface mem_port_arbiter_if;
  // I-cache fill path (read-only block fills)
  logic        i_req;
  logic [15:0] i_addr;
  logic        i_grant;
  logic        i_fill_valid;
  logic [15:0] i_fill_addr;
  logic [15:0] i_fill_data;
  logic        i_done;
  // D-cache path (block fills and single-word stores)
  logic        d_req;
  logic        d_we;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_grant;
  logic        d_fill_valid;
  logic [15:0] d_fill_addr;
  logic [15:0] d_fill_data;
  logic        d_done;
  // Pipelined main-memory port
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_valid;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_valid,
    output i_grant, i_fill_valid, i_fill_addr, i_fill_data, i_done,
    output d_grant, d_fill_valid, d_fill_addr, d_fill_data, d_done,
    output mem_en, mem_wr, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_valid,
    input  i_grant, i_fill_valid, i_fill_addr, i_fill_data, i_done,
    input  d_grant, d_fill_valid, d_fill_addr, d_fill_data, d_done,
    input  mem_en, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one pipelined main-memory port between the I-cache fill path and
//   the D-cache path (block fills and write-through stores). A block fill
//   issues one word address per cycle and tags each returned word with its
//   byte address. I wins ties unless I owned the previous transaction, so D
//   never waits behind more than one I transaction.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : mem_port_arbiter_if.slave (I side, D side, memory port)
module mem_port_arbiter #(
  parameter int unsigned WORDS = 8,
  parameter int unsigned CNT_W = 3
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  // Byte-offset bits within one block.
  localparam int unsigned OFF_W = CNT_W + 1;
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(WORDS - 1);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StIFill  = 3'd1;
  localparam logic [2:0] StDFill  = 3'd2;
  localparam logic [2:0] StDWrite = 3'd3;
  localparam logic [2:0] StDone   = 3'd4;

  localparam logic OwnI = 1'b0;
  localparam logic OwnD = 1'b1;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0] ret_cnt_q, ret_cnt_d;
  logic             issuing_q, issuing_d;
  logic [14:0]      addr_q, addr_d;  // word address; byte bit 0 is always dropped
  logic [15:0]      wdata_q, wdata_d;
  logic             owner_q, owner_d;
  logic             last_owner_q, last_owner_d;

  logic             pick_dside;
  logic             in_fill;
  logic             issue_now;
  logic             ret_hit;
  logic [15:0]      issue_addr;
  logic [15:0]      ret_addr;

  // Tie goes to D only when I owned the previous transaction.
  assign pick_dside = bus.d_req && (!bus.i_req || (last_owner_q == OwnI));

  always_comb begin
    state_d      = state_q;
    issue_cnt_d  = issue_cnt_q;
    ret_cnt_d    = ret_cnt_q;
    issuing_d    = issuing_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    case (state_q)
      StIdle: begin
        if (bus.i_req || bus.d_req) begin
          owner_d      = pick_dside ? OwnD : OwnI;
          last_owner_d = pick_dside ? OwnD : OwnI;
          addr_d       = pick_dside ? bus.d_addr[15:1] : bus.i_addr[15:1];
          wdata_d      = bus.d_wdata;
          issue_cnt_d  = '0;
          ret_cnt_d    = '0;
          issuing_d    = 1'b1;
          if (!pick_dside)    state_d = StIFill;
          else if (bus.d_we)  state_d = StDWrite;
          else                state_d = StDFill;
        end
      end
      StIFill, StDFill: begin
        if (issuing_q) begin
          issue_cnt_d = issue_cnt_q + CNT_W'(1);
          if (issue_cnt_q == CntLast) issuing_d = 1'b0;
        end
        if (bus.mem_valid) begin
          ret_cnt_d = ret_cnt_q + CNT_W'(1);
          if (ret_cnt_q == CntLast) state_d = StDone;
        end
      end
      StDWrite: state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      issue_cnt_q  <= '0;
      ret_cnt_q    <= '0;
      issuing_q    <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      owner_q      <= OwnI;
      last_owner_q <= OwnD;
    end else begin
      state_q      <= state_d;
      issue_cnt_q  <= issue_cnt_d;
      ret_cnt_q    <= ret_cnt_d;
      issuing_q    <= issuing_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
    end
  end

  assign in_fill   = (state_q == StIFill) || (state_q == StDFill);
  assign issue_now = in_fill && issuing_q;
  assign ret_hit   = in_fill && bus.mem_valid;

  // Counters replace the in-block offset bits, so addresses never carry into the tag.
  assign issue_addr = {addr_q[14:OFF_W-1], issue_cnt_q, 1'b0};
  assign ret_addr   = {addr_q[14:OFF_W-1], ret_cnt_q, 1'b0};

  assign bus.i_grant      = (state_q == StIFill);
  assign bus.i_fill_valid = ret_hit && (state_q == StIFill);
  assign bus.i_fill_addr  = bus.i_fill_valid ? ret_addr : '0;
  assign bus.i_fill_data  = bus.i_fill_valid ? bus.mem_rdata : '0;
  assign bus.i_done       = (state_q == StDone) && (owner_q == OwnI);

  assign bus.d_grant      = (state_q == StDFill) || (state_q == StDWrite);
  assign bus.d_fill_valid = ret_hit && (state_q == StDFill);
  assign bus.d_fill_addr  = bus.d_fill_valid ? ret_addr : '0;
  assign bus.d_fill_data  = bus.d_fill_valid ? bus.mem_rdata : '0;
  assign bus.d_done       = (state_q == StDone) && (owner_q == OwnD);

  assign bus.mem_en    = issue_now || (state_q == StDWrite);
  assign bus.mem_wr    = (state_q == StDWrite);
  assign bus.mem_addr  = issue_now               ? issue_addr :
                         (state_q == StDWrite)   ? {addr_q, 1'b0} : '0;
  assign bus.mem_wdata = (state_q == StDWrite) ? wdata_q : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Self-checking bench for mem_port_arbiter: a fixed-latency pipelined memory
//   model, a negedge monitor that logs issues/fills/dones/grant starts, and one
//   task per scenario comparing the log against values derived from the
//   arbitration and addressing rules.
module tb_mem_port_arbiter;
  localparam int unsigned WORDS = 8;
  localparam int unsigned CNT_W = 3;
  localparam int TMO = 300;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus ();
  mem_port_arbiter #(.WORDS(WORDS), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: read issued in cycle c returns in cycle c+lat.
  int          lat = 4;
  logic        stray = 1'b0;
  logic [7:0]  pv = '0;
  logic [15:0] pa [8];
  always @(posedge clk) begin
    pv <= {pv[6:0], bus.mem_en && !bus.mem_wr};
    for (int k = 7; k > 0; k--) pa[k] <= pa[k-1];
    pa[0] <= bus.mem_addr;
  end

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0] ^ 8'h3C, a[15:8] ^ 8'hA5};
  endfunction

  function automatic logic [15:0] base_of(input logic [15:0] a);
    return a - (a % 16'(2 * WORDS));
  endfunction

  assign bus.mem_valid = pv[lat-1] | stray;
  assign bus.mem_rdata = stray ? 16'hDEAD : mem_word(pa[lat-1]);

  logic [103:0] outs;
  assign outs = {bus.i_grant, bus.i_fill_valid, bus.i_fill_addr, bus.i_fill_data, bus.i_done,
                 bus.d_grant, bus.d_fill_valid, bus.d_fill_addr, bus.d_fill_data, bus.d_done,
                 bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_wdata};

  // Monitor log
  int          iss_cyc[$];
  logic [15:0] iss_addr[$];
  logic        iss_wr[$];
  logic [15:0] iss_wd[$];
  int          fil_cyc[$];
  bit          fil_d[$];
  logic [15:0] fil_addr[$];
  logic [15:0] fil_data[$];
  int          don_cyc[$];
  bit          don_d[$];
  int          gnt_cyc[$];
  bit          gnt_d[$];
  int          viol = 0;

  initial begin
    logic ig_prev, dg_prev;
    ig_prev = 1'b0;
    dg_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.mem_en === 1'b1) begin
        iss_cyc.push_back(cyc); iss_addr.push_back(bus.mem_addr);
        iss_wr.push_back(bus.mem_wr); iss_wd.push_back(bus.mem_wdata);
      end
      if (bus.i_fill_valid === 1'b1) begin
        fil_cyc.push_back(cyc); fil_d.push_back(1'b0);
        fil_addr.push_back(bus.i_fill_addr); fil_data.push_back(bus.i_fill_data);
      end
      if (bus.d_fill_valid === 1'b1) begin
        fil_cyc.push_back(cyc); fil_d.push_back(1'b1);
        fil_addr.push_back(bus.d_fill_addr); fil_data.push_back(bus.d_fill_data);
      end
      if (bus.i_done === 1'b1) begin don_cyc.push_back(cyc); don_d.push_back(1'b0); end
      if (bus.d_done === 1'b1) begin don_cyc.push_back(cyc); don_d.push_back(1'b1); end
      if (bus.i_grant === 1'b1 && !ig_prev) begin gnt_cyc.push_back(cyc); gnt_d.push_back(1'b0); end
      if (bus.d_grant === 1'b1 && !dg_prev) begin gnt_cyc.push_back(cyc); gnt_d.push_back(1'b1); end
      ig_prev = (bus.i_grant === 1'b1);
      dg_prev = (bus.d_grant === 1'b1);
      if ((bus.i_grant && bus.d_grant) || (bus.i_fill_valid && !bus.i_grant) ||
          (bus.d_fill_valid && !bus.d_grant) || (bus.i_done && bus.d_done) ||
          ((bus.i_done || bus.d_done) && (bus.i_grant || bus.d_grant)))
        viol++;
    end
  end

  task automatic mon_clear();
    iss_cyc.delete(); iss_addr.delete(); iss_wr.delete(); iss_wd.delete();
    fil_cyc.delete(); fil_d.delete(); fil_addr.delete(); fil_data.delete();
    don_cyc.delete(); don_d.delete(); gnt_cyc.delete(); gnt_d.delete();
    viol = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (8) tick();
  endtask

  task automatic wait_done(input bit side, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < TMO; n++) begin
      @(negedge clk);
      if ((side ? bus.d_done : bus.i_done) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Requesters used by the arbitration scenario; addresses/types logged for the model.
  logic [15:0] ia_q[$];
  logic [15:0] da_q[$];
  logic [15:0] dd_q[$];
  bit          dw_q[$];

  task automatic i_agent(input int n, output bit ok);
    bit got;
    logic [15:0] a;
    ok = 1'b1;
    for (int t = 0; t < n; t++) begin
      a = 16'($urandom);
      ia_q.push_back(a);
      bus.i_addr = a;
      bus.i_req = 1'b1;
      wait_done(1'b0, got);
      if (!got) ok = 1'b0;
    end
    bus.i_req = 1'b0;
  endtask

  task automatic d_agent(input int n, output bit ok);
    bit got;
    logic [15:0] a, wd;
    bit we;
    ok = 1'b1;
    for (int t = 0; t < n; t++) begin
      a = 16'($urandom); wd = 16'($urandom); we = 1'($urandom_range(0, 1));
      da_q.push_back(a); dd_q.push_back(wd); dw_q.push_back(we);
      bus.d_addr = a; bus.d_wdata = wd; bus.d_we = we;
      bus.d_req = 1'b1;
      wait_done(1'b1, got);
      if (!got) ok = 1'b0;
    end
    bus.d_req = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    stray = 1'b0;
    rst = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    total++;
    if (outs !== '0) begin bad++; $display("FAIL reset_outputs: got %h want 0", outs); end
    rst = 1'b0;
    stray = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      total++;
      if (outs !== '0) begin bad++; $display("FAIL idle_stray_return: got %h want 0", outs); end
    end
    stray = 1'b0;
    repeat (8) tick();
  endtask

  task automatic test_single_i_miss();
    int t0;
    bit ok;
    logic [15:0] ea;
    do_reset(); lat = 4; mon_clear();
    t0 = cyc;
    bus.i_addr = 16'h1236; bus.i_req = 1'b1;
    wait_done(1'b0, ok);
    bus.i_req = 1'b0;
    @(negedge clk);
    total++;
    if (outs !== '0) begin bad++; $display("FAIL i_miss_idle_after: got %h want 0", outs); end
    repeat (3) @(negedge clk);
    total++;
    if (!ok) begin bad++; $display("FAIL i_miss_timeout: got none want i_done"); end
    total++;
    if (gnt_cyc.size() != 1 || gnt_d[0] !== 1'b0 || gnt_cyc[0] != t0 + 1)
      begin bad++; $display("FAIL i_miss_grant: got n=%0d cyc=%0d want n=1 cyc=%0d",
                            gnt_cyc.size(), gnt_cyc[0], t0 + 1); end
    for (int k = 0; k < 8; k++) begin
      ea = 16'h1230 + 16'(2 * k);
      total++;
      if (iss_addr.size() <= k || iss_addr[k] !== ea || iss_wr[k] !== 1'b0 || iss_cyc[k] != t0 + 1 + k)
        begin bad++; $display("FAIL i_miss_issue%0d: got %h@%0d want %h@%0d", k, iss_addr[k],
                              iss_cyc[k], ea, t0 + 1 + k); end
      total++;
      if (fil_addr.size() <= k || fil_d[k] !== 1'b0 || fil_addr[k] !== ea ||
          fil_data[k] !== mem_word(ea) || fil_cyc[k] != t0 + 5 + k)
        begin bad++; $display("FAIL i_miss_fill%0d: got %h/%h@%0d want %h/%h@%0d", k, fil_addr[k],
                              fil_data[k], fil_cyc[k], ea, mem_word(ea), t0 + 5 + k); end
    end
    total++;
    if (iss_addr.size() != 8 || fil_addr.size() != 8 || don_cyc.size() != 1 ||
        don_d[0] !== 1'b0 || don_cyc[0] != t0 + 13)
      begin bad++; $display("FAIL i_miss_done: got iss=%0d fil=%0d done=%0d@%0d want 8 8 1@%0d",
                            iss_addr.size(), fil_addr.size(), don_cyc.size(), don_cyc[0], t0 + 13); end
  endtask

  task automatic test_d_store();
    int t0;
    bit ok;
    logic [15:0] a, wd;
    do_reset(); mon_clear();
    stray = 1'b1;  // returns during a store and its DONE must be ignored
    t0 = cyc;
    bus.d_we = 1'b1; bus.d_addr = 16'h4003; bus.d_wdata = 16'hBEEF; bus.d_req = 1'b1;
    wait_done(1'b1, ok);
    bus.d_req = 1'b0;
    @(negedge clk);
    stray = 1'b0;
    total++;
    if (!ok || iss_addr.size() != 1 || iss_wr[0] !== 1'b1 || iss_addr[0] !== 16'h4002 ||
        iss_wd[0] !== 16'hBEEF || iss_cyc[0] != t0 + 1)
      begin bad++; $display("FAIL store_issue: got n=%0d %h/%h@%0d want 1 4002/beef@%0d",
                            iss_addr.size(), iss_addr[0], iss_wd[0], iss_cyc[0], t0 + 1); end
    total++;
    if (don_cyc.size() != 1 || don_d[0] !== 1'b1 || don_cyc[0] != t0 + 2 || fil_addr.size() != 0)
      begin bad++; $display("FAIL store_done: got done=%0d@%0d fills=%0d want 1@%0d fills=0",
                            don_cyc.size(), don_cyc[0], fil_addr.size(), t0 + 2); end
    for (int n = 0; n < 5; n++) begin
      mon_clear();
      tick();
      a = 16'($urandom); wd = 16'($urandom);
      bus.d_addr = a; bus.d_wdata = wd; bus.d_req = 1'b1;
      tick();
      bus.d_addr = ~a; bus.d_wdata = ~wd;  // post-grant changes must not leak
      wait_done(1'b1, ok);
      bus.d_req = 1'b0;
      total++;
      if (!ok || iss_addr.size() != 1 || iss_addr[0] !== a - (a % 2) || iss_wd[0] !== wd ||
          iss_wr[0] !== 1'b1 || fil_addr.size() != 0)
        begin bad++; $display("FAIL rand_store%0d: got %h/%h want %h/%h", n, iss_addr[0],
                              iss_wd[0], a - (a % 2), wd); end
    end
  endtask

  task automatic test_simultaneous();
    bit ok1, ok2;
    logic [15:0] ai, ad, ea;
    do_reset(); lat = 4; mon_clear();
    ai = 16'($urandom); ad = 16'($urandom);
    bus.i_addr = ai; bus.d_addr = ad; bus.d_we = 1'b0;
    bus.i_req = 1'b1; bus.d_req = 1'b1;
    wait_done(1'b0, ok1);
    bus.i_req = 1'b0;
    wait_done(1'b1, ok2);
    bus.d_req = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (!ok1 || !ok2 || gnt_cyc.size() != 2 || gnt_d[0] !== 1'b0 || gnt_d[1] !== 1'b1)
      begin bad++; $display("FAIL simul_order: got n=%0d first_d=%0d want I then D",
                            gnt_cyc.size(), gnt_d[0]); end
    total++;
    if (don_cyc.size() != 2 || gnt_cyc.size() != 2 || gnt_cyc[1] != don_cyc[0] + 2)
      begin bad++; $display("FAIL simul_d_gap: got %0d want %0d", gnt_cyc[1], don_cyc[0] + 2); end
    total++;
    if (viol != 0) begin bad++; $display("FAIL simul_exclusive: got %0d bad cycles want 0", viol); end
    for (int k = 0; k < 16; k++) begin
      ea = base_of(k < 8 ? ai : ad) + 16'(2 * (k % 8));
      total++;
      if (fil_addr.size() <= k || fil_d[k] !== (k >= 8) || fil_addr[k] !== ea ||
          fil_data[k] !== mem_word(ea))
        begin bad++; $display("FAIL simul_fill%0d: got %h/%h want %h/%h", k, fil_addr[k],
                              fil_data[k], ea, mem_word(ea)); end
    end
  endtask

  task automatic test_anti_starvation();
    bit ok_i, ok_d, last_d, pick;
    int ni, nd, fi, si, ii, di, g;
    logic [15:0] a, wd, ea;
    bit st;
    bit exp_side[$];
    do_reset(); lat = $urandom_range(1, 6); mon_clear();
    ia_q.delete(); da_q.delete(); dd_q.delete(); dw_q.delete();
    fork
      i_agent(4, ok_i);
      d_agent(3, ok_d);
    join
    repeat (lat + 2) @(negedge clk);
    // With both sides pending, the side that did not go last wins; the reset owner is D.
    ni = 4; nd = 3; last_d = 1'b1;
    while (ni + nd > 0) begin
      pick = (nd > 0) && (ni == 0 || !last_d);
      exp_side.push_back(pick);
      if (pick) nd--; else ni--;
      last_d = pick;
    end
    total++;
    if (!ok_i || !ok_d) begin bad++; $display("FAIL starve_timeout: got i=%0d d=%0d want 1 1", ok_i, ok_d); end
    total++;
    if (viol != 0) begin bad++; $display("FAIL starve_exclusive: got %0d bad cycles want 0", viol); end
    fi = 0; si = 0; ii = 0; di = 0;
    for (int j = 0; j < exp_side.size(); j++) begin
      g = (j < gnt_cyc.size()) ? gnt_cyc[j] : -1;
      total++;
      if (gnt_cyc.size() <= j || gnt_d[j] !== exp_side[j] || don_d[j] !== exp_side[j] ||
          (j > 0 && g != don_cyc[j-1] + 2))
        begin bad++; $display("FAIL starve_grant%0d: got side=%0d@%0d want side=%0d", j, gnt_d[j],
                              g, exp_side[j]); end
      if (exp_side[j]) begin a = da_q[di]; wd = dd_q[di]; st = dw_q[di]; di++; end
      else begin a = ia_q[ii]; wd = '0; st = 1'b0; ii++; end
      if (st) begin
        total++;
        if (iss_addr.size() <= si || iss_wr[si] !== 1'b1 || iss_addr[si] !== a - (a % 2) ||
            iss_wd[si] !== wd || iss_cyc[si] != g)
          begin bad++; $display("FAIL starve_store%0d: got %h/%h want %h/%h", j, iss_addr[si],
                                iss_wd[si], a - (a % 2), wd); end
        si++;
      end else begin
        for (int k = 0; k < 8; k++) begin
          ea = base_of(a) + 16'(2 * k);
          total++;
          if (iss_addr.size() <= si || iss_wr[si] !== 1'b0 || iss_addr[si] !== ea ||
              iss_cyc[si] != g + k || fil_addr.size() <= fi || fil_d[fi] !== exp_side[j] ||
              fil_addr[fi] !== ea || fil_data[fi] !== mem_word(ea) || fil_cyc[fi] != g + lat + k)
            begin bad++; $display("FAIL starve_word%0d_%0d: got %h/%h@%0d want %h/%h@%0d", j, k,
                                  fil_addr[fi], fil_data[fi], fil_cyc[fi], ea, mem_word(ea),
                                  g + lat + k); end
          si++; fi++;
        end
      end
    end
    total++;
    if (iss_addr.size() != si || fil_addr.size() != fi || don_cyc.size() != exp_side.size())
      begin bad++; $display("FAIL starve_counts: got iss=%0d fil=%0d done=%0d want %0d %0d %0d",
                            iss_addr.size(), fil_addr.size(), don_cyc.size(), si, fi,
                            exp_side.size()); end
  endtask

  task automatic test_reset_mid_fill();
    int t0, nz;
    bit ok;
    logic [15:0] a, ea;
    do_reset(); lat = 4; mon_clear();
    t0 = cyc;
    bus.d_addr = 16'($urandom); bus.d_we = 1'b0; bus.d_req = 1'b1;
    repeat (3) tick();  // third issue cycle
    rst = 1'b1; bus.d_req = 1'b0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (outs !== '0) begin bad++; $display("FAIL rst_mid_outs: got %h want 0", outs); end
    nz = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (outs !== '0) nz++;
    end
    total++;
    if (nz != 0 || fil_addr.size() != 0 || don_cyc.size() != 0 || iss_addr.size() != 3)
      begin bad++; $display("FAIL rst_mid_after: got nz=%0d fills=%0d dones=%0d iss=%0d want 0 0 0 3",
                            nz, fil_addr.size(), don_cyc.size(), iss_addr.size()); end
    mon_clear();
    tick();
    a = 16'($urandom);
    bus.i_addr = a; bus.i_req = 1'b1;
    wait_done(1'b0, ok);
    bus.i_req = 1'b0;
    total++;
    if (!ok || fil_addr.size() != 8 || don_cyc.size() != 1)
      begin bad++; $display("FAIL rst_mid_fresh: got ok=%0d fills=%0d want 1 8", ok, fil_addr.size()); end
    for (int k = 0; k < 8; k++) begin
      ea = base_of(a) + 16'(2 * k);
      total++;
      if (fil_addr.size() <= k || fil_d[k] !== 1'b0 || fil_addr[k] !== ea || fil_data[k] !== mem_word(ea))
        begin bad++; $display("FAIL rst_mid_fill%0d: got %h want %h", k, fil_addr[k], ea); end
    end
  endtask

  task automatic test_req_drop();
    bit ok;
    logic [15:0] ea;
    do_reset(); lat = $urandom_range(2, 5); mon_clear();
    bus.d_addr = 16'hFFF8; bus.d_we = 1'b0; bus.d_req = 1'b1;
    repeat (2) tick();
    bus.d_req = 1'b0; bus.d_addr = 16'($urandom); bus.d_we = 1'b1;
    wait_done(1'b1, ok);
    repeat (4) @(negedge clk);
    total++;
    if (!ok || don_cyc.size() != 1 || fil_addr.size() != 8 || iss_addr.size() != 8)
      begin bad++; $display("FAIL drop_counts: got done=%0d fills=%0d iss=%0d want 1 8 8",
                            don_cyc.size(), fil_addr.size(), iss_addr.size()); end
    for (int k = 0; k < 8; k++) begin
      ea = 16'hFFF0 + 16'(2 * k);
      total++;
      if (fil_addr.size() <= k || fil_d[k] !== 1'b1 || fil_addr[k] !== ea ||
          fil_data[k] !== mem_word(ea) || iss_addr[k] !== ea)
        begin bad++; $display("FAIL drop_word%0d: got %h/%h want %h", k, iss_addr[k], fil_addr[k], ea); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    test_reset();
    test_single_i_miss();
    test_d_store();
    test_simultaneous();
    test_anti_starvation();
    test_reset_mid_fill();
    test_req_drop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
